// File: rtl/rob.sv
// Reorder buffer: keeps in-flight instructions in program order and retires the
// oldest completed one per cycle into the architectural map and free list.
module rob #(
    parameter  int ROB_DEPTH = 32,
    localparam int IDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispatch_en_i,
    input  logic [4:0]       dispatch_areg_i,
    input  logic [5:0]       dispatch_preg_i,
    input  logic [5:0]       dispatch_old_preg_i,
    output logic [IDX_W-1:0] dispatch_idx_o,
    input  logic             cdb_en_i,
    input  logic [IDX_W-1:0] cdb_idx_i,
    input  logic             flush_i,
    output logic             retire_en_o,
    output logic [4:0]       retire_areg_idx_o,
    output logic [5:0]       retire_preg_o,
    output logic [5:0]       retire_old_preg_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    logic [4:0]           areg_q     [ROB_DEPTH];
    logic [5:0]           preg_q     [ROB_DEPTH];
    logic [5:0]           old_preg_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] done_q, done_d;

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    logic             dispatch_accept;
    logic             cdb_accept;
    logic [IDX_W-1:0] cdb_offset;

    assign full_o         = (count_q == FULL_CNT);
    assign empty_o        = (count_q == '0);
    assign dispatch_idx_o = tail_q;

    assign retire_en_o       = ~empty_o & done_q[head_q];
    assign retire_areg_idx_o = areg_q[head_q];
    assign retire_preg_o     = preg_q[head_q];
    assign retire_old_preg_o = old_preg_q[head_q];

    assign dispatch_accept = dispatch_en_i & ~full_o & ~flush_i;

    // Completions only count for live entries: distance from head must be below count.
    assign cdb_offset = cdb_idx_i - head_q;
    assign cdb_accept = cdb_en_i & ~flush_i & ({1'b0, cdb_offset} < count_q);

    // The tail is never inside the live window while a dispatch is accepted,
    // so a completion and an allocation can never target the same entry.
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_done
        assign done_d[gi] = (cdb_accept && cdb_idx_i == IDX_W'(gi)) ? 1'b1 :
                            (dispatch_accept && tail_q == IDX_W'(gi)) ? 1'b0 :
                            done_q[gi];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (IDX_W+1)'(dispatch_accept) - (IDX_W+1)'(retire_en_o);
        if (retire_en_o) begin
            head_d = head_q + IDX_W'(1);
        end
        if (dispatch_accept) begin
            tail_d = tail_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Payload needs no reset: an entry is only read once it has been dispatched.
    always_ff @(posedge clk) begin
        if (!rst && dispatch_accept) begin
            areg_q[tail_q]     <= dispatch_areg_i;
            preg_q[tail_q]     <= dispatch_preg_i;
            old_preg_q[tail_q] <= dispatch_old_preg_i;
        end
    end

endmodule

// File: doc/rob.md
# rob

Reorder buffer that holds in-flight instructions in program order and retires them one per cycle into the architectural map. Dispatch writes {destination areg, new preg, old preg} at the tail. The CDB marks entries complete by ROB index. The head entry retires when complete, driving the architectural map update and returning the old preg to the free list.

## Interface
- ROB_DEPTH, 32, number of entries; power of two; index width IDX_W = log2(ROB_DEPTH).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- dispatch_en_i  in  1  allocate tail entry this cycle.
- dispatch_areg_i  in  5  destination architectural reg.
- dispatch_preg_i  in  6  newly allocated physical reg.
- dispatch_old_preg_i  in  6  preg previously mapped to the areg (from the map table).
- dispatch_idx_o  out  IDX_W  index the dispatching instruction receives (= tail pointer).
- cdb_en_i  in  1  completion broadcast valid.
- cdb_idx_i  in  IDX_W  ROB index of the completing instruction.
- flush_i  in  1  squash all entries (mispredict/exception).
- retire_en_o  out  1  head entry retires this cycle.
- retire_areg_idx_o  out  5  head areg (to the arch map).
- retire_preg_o  out  6  head new preg (to the arch map).
- retire_old_preg_o  out  6  head old preg (to the free list).
- full_o  out  1  count == ROB_DEPTH.
- empty_o  out  1  count == 0.

## Operation
- Each entry holds: areg[4:0], preg[5:0], old_preg[5:0], done.
- State consists of head and tail pointers (IDX_W bits, wrap modulo ROB_DEPTH) and a count (IDX_W+1 bits, range 0..ROB_DEPTH).
- Dispatch accept condition: dispatch_en_i & ~full_o & ~flush_i.
  - Writes all fields at the tail and clears done.
  - Increments the tail.
- A dispatch while full_o=1 is dropped. This holds even if a retire occurs in the same cycle, because full_o reflects the registered count. No state changes for a dropped dispatch.
- Completion: when cdb_en_i & ~flush_i, set done[cdb_idx_i].
  - An index outside the valid window [head, head+count) is ignored.
  - Completing an already-done entry is harmless.
- Retire:
  - retire_en_o = ~empty_o & done[head].
  - retire_areg_idx_o, retire_preg_o and retire_old_preg_o always reflect the head entry. Their values are don't-care when retire_en_o=0.
  - When retire_en_o=1, the head increments at the edge.
- Count update: count_next = count + dispatch_accept - retire_en_o.
  - Simultaneous dispatch and retire leaves count unchanged.
- Flush:
  - At the edge with flush_i=1, head=tail=0, count=0 and all done bits are cleared.
  - Same-cycle dispatch and CDB inputs are ignored.
  - A retire_en_o asserted in the flush cycle is still a valid commit: the consumer acts on it.
- Reset (rst=1) produces the same state as flush.
  - Reset outputs: retire_en_o=0, full_o=0, empty_o=1, dispatch_idx_o=0.
  - rst has priority over every other input.
- dispatch_idx_o = tail, combinational from the registered pointer.

## Timing
- Dispatch-to-retire minimum latency is 2 cycles:
  - Cycle N: dispatch.
  - Cycle N+1: CDB completion.
  - Cycle N+2: retire_en_o=1.
- A CDB on the head entry at cycle N gives retire_en_o=1 at N+1. There is no same-cycle bypass from CDB to retire.
- Throughput is at most 1 dispatch and 1 retire per cycle.
- full_o and empty_o are derived from the registered count and change only after a clock edge.
- Pointer wrap: when tail=ROB_DEPTH-1, the tail becomes 0 after a dispatch. The head wraps the same way.

## Test plan
- Reset then idle:
  - Stimulus: rst for 2 cycles, then idle.
  - Required: empty_o=1, full_o=0, retire_en_o=0, dispatch_idx_o=0.
- Single instruction:
  - Stimulus: dispatch {areg=3, preg=40, old=3} at cycle 0; CDB idx 0 at cycle 1.
  - Required: retire_en_o=1 at cycle 2 with areg=3, preg=40, old_preg=3; empty_o=1 at cycle 3.
- Fill and wrap:
  - Stimulus: 32 dispatches; then one more dispatch.
  - Required: full_o=1; the extra dispatch is dropped and dispatch_idx_o stays 0.
  - Stimulus continued: complete and retire entry 0, then dispatch.
  - Required: the new entry gets idx 0 and full_o=1 again.
- Out-of-order completion:
  - Stimulus: dispatch 3; complete idx 2, then idx 1.
  - Required: no retire until idx 0 completes; then retires on 3 consecutive cycles in order 0, 1, 2.
- Simultaneous dispatch, completion and retire at count=5:
  - Required: count stays 5, tail and head each advance by 1.
- Flush:
  - Stimulus: 4 entries with the head done, flush_i=1, plus a same-cycle dispatch and CDB.
  - Required: retire_en_o=1 in the flush cycle; next cycle empty_o=1, dispatch_idx_o=0, retire_en_o=0.
